// File: rtl/calc_seq_if.sv
// Keypad-command and ALU handshake bundle for the calculator sequencer.
// master: the sequencer (consumes commands and ALU results, drives operands/op/start).
// slave : the surrounding keypad decoder / ALU side.
interface calc_seq_if #(
    parameter int W = 27
) ();
    logic [3:0]   cmd;
    logic         cmd_valid;
    logic         alu_done;
    logic [W-1:0] alu_result;
    logic         alu_ovf;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic [1:0]   alu_op;
    logic         alu_start;

    modport master (
        input  cmd, cmd_valid, alu_done, alu_result, alu_ovf,
        output operand_a, operand_b, alu_op, alu_start
    );

    modport slave (
        output cmd, cmd_valid, alu_done, alu_result, alu_ovf,
        input  operand_a, operand_b, alu_op, alu_start
    );
endinterface

// File: rtl/calc_seq_ctrl.sv
// Calculator command sequencer: decimal operand entry into binary registers,
// operator latching and a start/done handshake with the external ALU.
// Optional feature macro: CALC_CHAIN_EN -- when defined, an operator pressed
// while a result is shown continues the calculation with the result as A.
module calc_seq_ctrl #(
    parameter int W           = 27,
    parameter int MAX_DIGITS  = 8,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic            clock,
    input  logic            reset,
    calc_seq_if.master      bus,
    output logic [W-1:0]    disp_value,
    output logic [1:0]      status,
    output logic [2:0]      EA,
    output logic [2:0]      PE
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int TW = $clog2(ALU_TIMEOUT + 1);

    localparam logic [3:0] CMD_ADD = 4'b1010;
    localparam logic [3:0] CMD_SUB = 4'b1011;
    localparam logic [3:0] CMD_MUL = 4'b1100;
    localparam logic [3:0] CMD_EQ  = 4'b1110;
    localparam logic [3:0] CMD_CLR = 4'b1111;

    typedef enum logic [2:0] {
        S_A     = 3'd0,
        S_B     = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_RES   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t        state, nxt_state;
    logic [W-1:0]  a_reg, b_reg, res_reg;
    logic [W-1:0]  nxt_a, nxt_b, nxt_res;
    logic [CW-1:0] a_cnt, b_cnt, nxt_a_cnt, nxt_b_cnt;
    logic [1:0]    op_reg, nxt_op;
    logic [TW-1:0] tmo_cnt, nxt_tmo;
    logic          start_reg;

    logic          is_digit, is_op, is_eq, is_clr;
    logic [W-1:0]  digit_val;
    logic [1:0]    cmd_op;
    logic [W-1:0]  nxt_disp;
    logic [1:0]    nxt_status;

    // Decode the sampled keypad command into its classes.
    always_comb begin
        is_digit  = bus.cmd_valid && (bus.cmd <= 4'd9);
        is_op     = bus.cmd_valid && ((bus.cmd == CMD_ADD) || (bus.cmd == CMD_SUB) || (bus.cmd == CMD_MUL));
        is_eq     = bus.cmd_valid && (bus.cmd == CMD_EQ);
        is_clr    = bus.cmd_valid && (bus.cmd == CMD_CLR);
        digit_val = {{(W-4){1'b0}}, bus.cmd};
        cmd_op    = 2'(bus.cmd - CMD_ADD);
    end

    // Next-state and next-register computation; clear overrides everything.
    always_comb begin
        nxt_state = state;
        nxt_a     = a_reg;
        nxt_b     = b_reg;
        nxt_res   = res_reg;
        nxt_a_cnt = a_cnt;
        nxt_b_cnt = b_cnt;
        nxt_op    = op_reg;
        nxt_tmo   = tmo_cnt;
        if (is_clr) begin
            nxt_state = S_A;
            nxt_a     = '0;
            nxt_b     = '0;
            nxt_res   = '0;
            nxt_a_cnt = '0;
            nxt_b_cnt = '0;
            nxt_op    = 2'b00;
            nxt_tmo   = '0;
        end else begin
            case (state)
                S_A: begin
                    if (is_digit) begin
                        if (a_cnt != CW'(MAX_DIGITS)) begin
                            nxt_a     = a_reg * W'(10) + digit_val;
                            nxt_a_cnt = a_cnt + 1'b1;
                        end
                    end else if (is_op) begin
                        nxt_op    = cmd_op;
                        nxt_b     = '0;
                        nxt_b_cnt = '0;
                        nxt_state = S_B;
                    end
                end
                S_B: begin
                    if (is_digit) begin
                        if (b_cnt != CW'(MAX_DIGITS)) begin
                            nxt_b     = b_reg * W'(10) + digit_val;
                            nxt_b_cnt = b_cnt + 1'b1;
                        end
                    end else if (is_op) begin
                        if (b_cnt == '0) nxt_op = cmd_op;
                    end else if (is_eq) begin
                        if (b_cnt != '0) nxt_state = S_START;
                    end
                end
                S_START: begin
                    nxt_tmo   = '0;
                    nxt_state = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.alu_done) begin
                        if (bus.alu_ovf) begin
                            nxt_state = S_ERR;
                        end else begin
                            nxt_res   = bus.alu_result;
                            nxt_state = S_RES;
                        end
                    end else if (tmo_cnt == TW'(ALU_TIMEOUT - 1)) begin
                        nxt_state = S_ERR;
                    end else begin
                        nxt_tmo = tmo_cnt + 1'b1;
                    end
                end
                S_RES: begin
                    if (is_digit) begin
                        nxt_a     = digit_val;
                        nxt_a_cnt = CW'(1);
                        nxt_b     = '0;
                        nxt_b_cnt = '0;
                        nxt_state = S_A;
                    end
`ifdef CALC_CHAIN_EN
                    else if (is_op) begin
                        nxt_a     = res_reg;
                        nxt_a_cnt = CW'(MAX_DIGITS);
                        nxt_op    = cmd_op;
                        nxt_b     = '0;
                        nxt_b_cnt = '0;
                        nxt_state = S_B;
                    end
`else
                    else begin
                        nxt_state = S_RES;
                    end
`endif
                end
                S_ERR:   nxt_state = S_ERR;
                default: nxt_state = S_ERR;
            endcase
        end
    end

    // Display/status values for the state being entered, so they register in step with EA.
    always_comb begin
        nxt_disp   = '0;
        nxt_status = 2'b11;
        case (nxt_state)
            S_A: begin
                nxt_disp   = nxt_a;
                nxt_status = 2'b00;
            end
            S_B: begin
                nxt_disp   = (nxt_b_cnt == '0) ? nxt_a : nxt_b;
                nxt_status = 2'b00;
            end
            S_START, S_WAIT: begin
                nxt_disp   = nxt_b;
                nxt_status = 2'b01;
            end
            S_RES: begin
                nxt_disp   = nxt_res;
                nxt_status = 2'b10;
            end
            default: begin
                nxt_disp   = '0;
                nxt_status = 2'b11;
            end
        endcase
    end

    // Sequencer state, operand registers and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_A;
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            a_cnt      <= '0;
            b_cnt      <= '0;
            op_reg     <= 2'b00;
            tmo_cnt    <= '0;
            start_reg  <= 1'b0;
            disp_value <= '0;
            status     <= 2'b00;
        end else begin
            state      <= nxt_state;
            a_reg      <= nxt_a;
            b_reg      <= nxt_b;
            res_reg    <= nxt_res;
            a_cnt      <= nxt_a_cnt;
            b_cnt      <= nxt_b_cnt;
            op_reg     <= nxt_op;
            tmo_cnt    <= nxt_tmo;
            start_reg  <= (nxt_state == S_START);
            disp_value <= nxt_disp;
            status     <= nxt_status;
        end
    end

    assign bus.operand_a = a_reg;
    assign bus.operand_b = b_reg;
    assign bus.alu_op    = op_reg;
    assign bus.alu_start = start_reg;
    assign EA            = state;
    assign PE            = nxt_state;

endmodule
